// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default widths, register count and the
// write-arbiter FSM state encoding.
package regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

endpackage : regfile_pkg

// File: rtl/reg_write_arbiter_starve_counter.sv
// Saturating count of consecutive debug-port losses to the CPU.
// A clear request takes precedence over an increment.
module starve_counter #(
    parameter int LIM   = 4,
    parameter int CNT_W = $clog2(LIM + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LIM);

    logic [CNT_W-1:0] cnt_r;

    // Count losses, saturating at the limit; clear on a debug grant or idle debug port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_LIM)) begin
            cnt_r <= cnt_r + 1'b1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule : starve_counter

// File: rtl/reg_write_arbiter.sv
// Register-file write-port owner. After reset (or on clear_start) it zeroes
// every register, one per cycle, then arbitrates CPU and debug write requests.
// The CPU normally wins; after STARVE_LIM consecutive debug losses the debug
// port wins once. Every grant is followed by one idle arbitration cycle so a
// held request can never be written twice back-to-back.
module reg_write_arbiter #(
    parameter int DATA_W     = regfile_pkg::DATA_W,
    parameter int ADDR_W     = regfile_pkg::ADDR_W,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_start,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_data,
    output logic              cpu_gnt,
    output logic              dbg_gnt,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    import regfile_pkg::*;

    localparam int                CNT_W    = $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0]  CNT_LIM  = CNT_W'(STARVE_LIM);
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] idx_r, idx_s, cur_idx_s;

    logic              cpu_gnt_r, cpu_gnt_s;
    logic              dbg_gnt_r, dbg_gnt_s;
    logic              wr_en_r, wr_en_s;
    logic              busy_r, busy_s;
    logic [ADDR_W-1:0] wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0] wr_data_r, wr_data_s;

    logic [CNT_W-1:0]  starve_cnt_s;
    logic              starve_inc_s;
    logic              starve_clr_s;

    starve_counter #(
        .LIM   (STARVE_LIM),
        .CNT_W (CNT_W)
    ) u_starve_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc_s),
        .clr   (starve_clr_s),
        .cnt   (starve_cnt_s)
    );

    // A CPU grant while debug waits is a loss; a debug grant or idle debug port forgives.
    assign starve_inc_s = dbg_req & cpu_gnt_s;
    assign starve_clr_s = dbg_gnt_s | ~dbg_req;

    // State, clear index and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= CLEAR;
            idx_r     <= {ADDR_W{1'b0}};
            cpu_gnt_r <= 1'b0;
            dbg_gnt_r <= 1'b0;
            wr_en_r   <= 1'b0;
            busy_r    <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= {DATA_W{1'b0}};
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            cpu_gnt_r <= cpu_gnt_s;
            dbg_gnt_r <= dbg_gnt_s;
            wr_en_r   <= wr_en_s;
            busy_r    <= busy_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
        end
    end

    // Next state: walk the clear index to the last register, then arbitrate.
    always_comb begin
        state_s   = state_r;
        idx_s     = idx_r;
        cur_idx_s = clear_start ? {ADDR_W{1'b0}} : idx_r;
        case (state_r)
            CLEAR: begin
                if (cur_idx_s == LAST_IDX) begin
                    state_s = ARB;
                    idx_s   = {ADDR_W{1'b0}};
                end else begin
                    state_s = CLEAR;
                    idx_s   = cur_idx_s + 1'b1;
                end
            end
            ARB: begin
                if (clear_start) begin
                    state_s = CLEAR;
                    idx_s   = {ADDR_W{1'b0}};
                end else begin
                    state_s = ARB;
                    idx_s   = idx_r;
                end
            end
            default: begin
                state_s = CLEAR;
                idx_s   = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Output values for the next cycle: clear writes, or the arbitration winner.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        wr_en_s   = 1'b0;
        busy_s    = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        case (state_r)
            CLEAR: begin
                wr_en_s   = 1'b1;
                busy_s    = 1'b1;
                wr_addr_s = cur_idx_s;
                wr_data_s = {DATA_W{1'b0}};
            end
            ARB: begin
                if (clear_start || cpu_gnt_r || dbg_gnt_r) begin
                    // Clear takes over, or this is the idle slot after a grant.
                    wr_en_s = 1'b0;
                end else if (dbg_req && (starve_cnt_s == CNT_LIM)) begin
                    dbg_gnt_s = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_addr_s = dbg_addr;
                    wr_data_s = dbg_data;
                end else if (cpu_req) begin
                    cpu_gnt_s = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_addr_s = cpu_addr;
                    wr_data_s = cpu_data;
                end else if (dbg_req) begin
                    dbg_gnt_s = 1'b1;
                    wr_en_s   = 1'b1;
                    wr_addr_s = dbg_addr;
                    wr_data_s = dbg_data;
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            default: begin
                wr_en_s = 1'b0;
            end
        endcase
    end

    assign cpu_gnt = cpu_gnt_r;
    assign dbg_gnt = dbg_gnt_r;
    assign wr_en   = wr_en_r;
    assign wr_addr = wr_addr_r;
    assign wr_data = wr_data_r;
    assign busy    = busy_r;

endmodule : reg_write_arbiter
